rv_multicycle_ctrl: RTL and testbench

- Parametrised multi-cycle RV32I control unit; successor to the single-cycle combinational decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/MDU/WB with ready handshakes to instruction memory, data memory and an optional multiply/divide unit.
- Emits registered-decode control signals and a retired-instruction counter.
- Sits between the instruction register/memories and the datapath (ALU, register file, PC).

---
 rtl/rv_multicycle_ctrl_if.sv | 60 ++++++
 rtl/rv_multicycle_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// rv_multicycle_ctrl_if
//   Bundles everything the multi-cycle RV32I controller exchanges with the
//   instruction memory, data memory, multiply/divide unit and datapath.
//   Signal names keep their i_/o_ prefixes as seen from the controller.
//
//   Handshake semantics (all three links): the controller raises a request
//   (o_imem_req, o_dmem_req) or waits in MDU, and holds it until the
//   matching ready/done input is sampled high on a rising clock edge.
//   i_instr is only meaningful in a cycle where i_imem_ready is high in
//   FETCH. A ready seen while no request is raised is ignored.
//
//   Modports:
//     master - controller side (drives o_*, reads i_*)
//     slave  - memories/MDU/datapath side (drives i_*, reads o_*)
// ---------------------------------------------------------------------------
interface rv_multicycle_ctrl_if #(
  parameter int unsigned RET_W = 32
);
  logic [31:0]      i_instr;
  logic             i_imem_ready;
  logic             i_dmem_ready;
  logic             i_mdu_done;

  logic [2:0]       o_state;
  logic             o_imem_req;
  logic             o_ir_wr_en;
  logic             o_dmem_req;
  logic             o_dmem_wr_en;
  logic             o_mdu_start;
  logic             o_alu_input_sel;
  logic [2:0]       o_alu_op_sel;
  logic             o_alu_sub_sel;
  logic             o_alu_sign_sel;
  logic             o_alu_arith_sel;
  logic             o_jump_sel;
  logic             o_jump_type_sel;
  logic             o_pc_wr_en;
  logic [2:0]       o_reg_wr_sel;
  logic             o_reg_wr_en;
  logic             o_halt;
  logic             o_trap;
  logic [RET_W-1:0] o_retired;

  modport master (
    input  i_instr, i_imem_ready, i_dmem_ready, i_mdu_done,
    output o_state, o_imem_req, o_ir_wr_en, o_dmem_req, o_dmem_wr_en,
           o_mdu_start, o_alu_input_sel, o_alu_op_sel, o_alu_sub_sel,
           o_alu_sign_sel, o_alu_arith_sel, o_jump_sel, o_jump_type_sel,
           o_pc_wr_en, o_reg_wr_sel, o_reg_wr_en, o_halt, o_trap, o_retired
  );

  modport slave (
    output i_instr, i_imem_ready, i_dmem_ready, i_mdu_done,
    input  o_state, o_imem_req, o_ir_wr_en, o_dmem_req, o_dmem_wr_en,
           o_mdu_start, o_alu_input_sel, o_alu_op_sel, o_alu_sub_sel,
           o_alu_sign_sel, o_alu_arith_sel, o_jump_sel, o_jump_type_sel,
           o_pc_wr_en, o_reg_wr_sel, o_reg_wr_en, o_halt, o_trap, o_retired
  );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// rv_multicycle_ctrl
//   Multi-cycle RV32I control unit. Each instruction walks through
//   FETCH -> DECODE -> EXEC -> (MEM | MDU) -> WB, waiting on the memory and
//   MDU handshakes. Control fields are decoded once in DECODE into a
//   register so they stay stable for the rest of the instruction.
//   HALT (SYSTEM opcode) and TRAP (illegal opcode / timeout) are absorbing
//   until reset. o_retired counts completed instructions.
//
//   Ports:
//     i_clk  - clock
//     i_rst  - asynchronous active-low reset; all outputs read 0 while low
//     bus    - rv_multicycle_ctrl_if.master (memories, MDU, datapath)
//
//   Parameters:
//     MEM_TIMEOUT - max cycles waiting in FETCH/MEM before TRAP (0 = off)
//     EN_MUL      - 1 routes RV32M encodings to the MDU, 0 traps them
//     RET_W       - width of the retired-instruction counter
// ---------------------------------------------------------------------------
module rv_multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter bit          EN_MUL      = 1'b0,
  parameter int unsigned RET_W       = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  rv_multicycle_ctrl_if.master bus
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_MDU    = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_REG    = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] WB_ALU   = 3'd0;
  localparam logic [2:0] WB_LOAD  = 3'd1;
  localparam logic [2:0] WB_LUI   = 3'd2;
  localparam logic [2:0] WB_AUIPC = 3'd3;
  localparam logic [2:0] WB_PC4   = 3'd4;

  typedef struct packed {
    logic       alu_input_sel;
    logic [2:0] alu_op_sel;
    logic       alu_sub_sel;
    logic       alu_sign_sel;
    logic       alu_arith_sel;
    logic       jump_sel;
    logic       jump_type_sel;
    logic [2:0] reg_wr_sel;
    logic       rd_wr;       // writes a register other than x0
    logic       is_load;
    logic       is_store;
    logic       is_branch;
  } dec_t;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [21:0]      ir;          // {funct7, funct3, rd, opcode}
  dec_t             dec_q;
  dec_t             dec_d;
  logic [31:0]      wait_cnt;
  logic             mdu_started;
  logic [RET_W-1:0] retired;

  logic             dec_halt;
  logic             dec_bad;
  logic             dec_m;
  logic             timeout_hit;
  logic             retire;

  // rs1/rs2 fields belong to the datapath; the controller never looks at them.
  logic unused_instr_bits;
  assign unused_instr_bits = ^bus.i_instr[24:15];

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic [6:0] funct7;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign funct7 = ir[21:15];

  // Combinational decode of the latched instruction, captured in DECODE.
  always_comb begin
    dec_d    = '0;
    dec_halt = 1'b0;
    dec_bad  = 1'b0;
    dec_m    = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_d.reg_wr_sel = WB_LUI;
        dec_d.rd_wr      = 1'b1;
      end
      OPC_AUIPC: begin
        dec_d.reg_wr_sel = WB_AUIPC;
        dec_d.rd_wr      = 1'b1;
      end
      OPC_JAL: begin
        dec_d.jump_sel   = 1'b1;
        dec_d.reg_wr_sel = WB_PC4;
        dec_d.rd_wr      = 1'b1;
      end
      OPC_JALR: begin
        dec_d.jump_sel      = 1'b1;
        dec_d.jump_type_sel = 1'b1;
        dec_d.alu_input_sel = 1'b1;
        dec_d.reg_wr_sel    = WB_PC4;
        dec_d.rd_wr         = 1'b1;
      end
      OPC_BRANCH: begin
        dec_d.is_branch    = 1'b1;
        dec_d.alu_sign_sel = funct3[1];  // bltu/bgeu compare unsigned
      end
      OPC_LOAD: begin
        dec_d.is_load       = 1'b1;
        dec_d.alu_input_sel = 1'b1;
        dec_d.reg_wr_sel    = WB_LOAD;
        dec_d.rd_wr         = 1'b1;
      end
      OPC_STORE: begin
        dec_d.is_store      = 1'b1;
        dec_d.alu_input_sel = 1'b1;
      end
      OPC_IMM: begin
        dec_d.alu_input_sel = 1'b1;
        // slti shares the compare op with sltiu; sign_sel tells them apart
        dec_d.alu_op_sel    = {funct3[2], funct3[1], funct3[0] | (funct3 == 3'b010)};
        dec_d.alu_sign_sel  = (funct3 == 3'b011);
        // bit 30 of srai is the arithmetic flag; for addi it is immediate data
        dec_d.alu_arith_sel = (funct3 == 3'b101) & funct7[5];
        dec_d.rd_wr         = 1'b1;
      end
      OPC_REG: begin
        if (funct7 == 7'b0000001) begin
          dec_m       = 1'b1;
          dec_d.rd_wr = 1'b1;
        end else begin
          dec_d.alu_op_sel    = {funct3[2], funct3[1], funct3[0] | (funct3 == 3'b010)};
          dec_d.alu_sub_sel   = (funct3 == 3'b000) & funct7[5];
          dec_d.alu_sign_sel  = (funct3 == 3'b011);
          dec_d.alu_arith_sel = (funct3 == 3'b101) & funct7[5];
          dec_d.rd_wr         = 1'b1;
        end
      end
      OPC_FENCE: begin
        // single in-order master: fence retires as a no-op through WB
      end
      OPC_SYSTEM: dec_halt = 1'b1;
      default:    dec_bad  = 1'b1;
    endcase
    dec_d.rd_wr = dec_d.rd_wr & (rd != 5'd0);
  end

  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == MEM_TIMEOUT - 1);

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (bus.i_imem_ready)  state_nxt = S_DECODE;
        else if (timeout_hit)  state_nxt = S_TRAP;
      end
      S_DECODE: begin
        if (dec_halt)          state_nxt = S_HALT;
        else if (dec_bad)      state_nxt = S_TRAP;
        else if (dec_m)        state_nxt = EN_MUL ? S_MDU : S_TRAP;
        else                   state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (dec_q.is_load || dec_q.is_store) state_nxt = S_MEM;
        else if (dec_q.is_branch)            state_nxt = S_FETCH;
        else                                 state_nxt = S_WB;
      end
      S_MEM: begin
        if (bus.i_dmem_ready)  state_nxt = dec_q.is_load ? S_WB : S_FETCH;
        else if (timeout_hit)  state_nxt = S_TRAP;
      end
      S_MDU: begin
        if (bus.i_mdu_done)    state_nxt = S_WB;
      end
      S_WB:    state_nxt = S_FETCH;
      default: state_nxt = state;  // HALT and TRAP hold until reset
    endcase
  end

  assign retire = ((state == S_EXEC) && dec_q.is_branch) ||
                  ((state == S_MEM) && dec_q.is_store && bus.i_dmem_ready) ||
                  (state == S_WB);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= S_FETCH;
      ir          <= '0;
      dec_q       <= '0;
      wait_cnt    <= '0;
      mdu_started <= 1'b0;
      retired     <= '0;
    end else begin
      state <= state_nxt;
      if ((state == S_FETCH) && bus.i_imem_ready)
        ir <= {bus.i_instr[31:25], bus.i_instr[14:12], bus.i_instr[11:7], bus.i_instr[6:0]};
      if (state == S_DECODE)
        dec_q <= dec_d;
      // wait counter restarts on every state change
      if (state_nxt != state)
        wait_cnt <= '0;
      else if ((state == S_FETCH) || (state == S_MEM))
        wait_cnt <= wait_cnt + 32'd1;
      mdu_started <= (state == S_MDU) && (state_nxt == S_MDU);
      if (retire)
        retired <= retired + RET_W'(1);
    end
  end

  // Strobes are gated by i_rst so FETCH's request stays low while reset is held.
  assign bus.o_state         = state;
  assign bus.o_imem_req      = i_rst && (state == S_FETCH);
  assign bus.o_ir_wr_en      = i_rst && (state == S_FETCH) && bus.i_imem_ready;
  assign bus.o_dmem_req      = i_rst && (state == S_MEM);
  assign bus.o_dmem_wr_en    = i_rst && (state == S_MEM) && dec_q.is_store;
  assign bus.o_mdu_start     = i_rst && (state == S_MDU) && !mdu_started;
  assign bus.o_pc_wr_en      = i_rst && retire;
  assign bus.o_reg_wr_en     = i_rst && (state == S_WB) && dec_q.rd_wr;
  assign bus.o_halt          = i_rst && (state == S_HALT);
  assign bus.o_trap          = i_rst && (state == S_TRAP);
  assign bus.o_alu_input_sel = dec_q.alu_input_sel;
  assign bus.o_alu_op_sel    = dec_q.alu_op_sel;
  assign bus.o_alu_sub_sel   = dec_q.alu_sub_sel;
  assign bus.o_alu_sign_sel  = dec_q.alu_sign_sel;
  assign bus.o_alu_arith_sel = dec_q.alu_arith_sel;
  assign bus.o_jump_sel      = dec_q.jump_sel;
  assign bus.o_jump_type_sel = dec_q.jump_type_sel;
  assign bus.o_reg_wr_sel    = dec_q.reg_wr_sel;
  assign bus.o_retired       = retired;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv_multicycle_ctrl
//   Directed bench for rv_multicycle_ctrl. Two instances share clock/reset:
//   dut_a (no timeout, RV32M enabled) and dut_b (MEM_TIMEOUT=4, RV32M off).
//   Inputs change 1 time unit after the rising edge; outputs are checked
//   2 time units later, well clear of either clock edge.
// ---------------------------------------------------------------------------
module tb_rv_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rv_multicycle_ctrl_if #(.RET_W(32)) a_bus ();
  rv_multicycle_ctrl_if #(.RET_W(32)) b_bus ();

  rv_multicycle_ctrl #(.MEM_TIMEOUT(0), .EN_MUL(1'b1), .RET_W(32)) dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (a_bus)
  );

  rv_multicycle_ctrl #(.MEM_TIMEOUT(4), .EN_MUL(1'b0), .RET_W(32)) dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (b_bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int a_ret    = 0;   // expected retired count for dut_a
  int b_ret    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Pulse a reset across one edge, then release; leaves both DUTs in FETCH.
  task automatic do_reset();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    a_ret = 0;
    b_ret = 0;
  endtask

  // One-cycle fetch with ready; returns in the DECODE cycle.
  task automatic fetch_a(input logic [31:0] instr);
    a_bus.i_instr      = instr;
    a_bus.i_imem_ready = 1'b1;
    settle();
    check("a_fetch_ir_wr", a_bus.o_ir_wr_en, 1);
    cyc();
    a_bus.i_imem_ready = 1'b0;
  endtask

  task automatic fetch_b(input logic [31:0] instr);
    b_bus.i_instr      = instr;
    b_bus.i_imem_ready = 1'b1;
    settle();
    check("b_fetch_ir_wr", b_bus.o_ir_wr_en, 1);
    cyc();
    b_bus.i_imem_ready = 1'b0;
  endtask

  // ALU-class instruction: FETCH, DECODE, EXEC (fields), WB, back to FETCH.
  task automatic run_alu_a(input string tag, input logic [31:0] instr,
                           input logic in_sel, input logic [2:0] op,
                           input logic sub, input logic sign, input logic arith,
                           input logic wr);
    fetch_a(instr);
    settle();
    check({tag, "_decode"}, a_bus.o_state, 1);
    cyc();
    settle();
    check({tag, "_exec"},   a_bus.o_state, 2);
    check({tag, "_in_sel"}, a_bus.o_alu_input_sel, in_sel);
    check({tag, "_op"},     a_bus.o_alu_op_sel, op);
    check({tag, "_sub"},    a_bus.o_alu_sub_sel, sub);
    check({tag, "_sign"},   a_bus.o_alu_sign_sel, sign);
    check({tag, "_arith"},  a_bus.o_alu_arith_sel, arith);
    cyc();
    settle();
    check({tag, "_wb"},     a_bus.o_state, 4);
    check({tag, "_pc_wr"},  a_bus.o_pc_wr_en, 1);
    check({tag, "_reg_wr"}, a_bus.o_reg_wr_en, wr);
    cyc();
    a_ret++;
    settle();
    check({tag, "_fetch"},  a_bus.o_state, 0);
    check({tag, "_ret"},    a_bus.o_retired, a_ret);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_bus.i_instr = '0; a_bus.i_imem_ready = 1'b1;
    a_bus.i_dmem_ready = 1'b0; a_bus.i_mdu_done = 1'b0;
    b_bus.i_instr = '0; b_bus.i_imem_ready = 1'b0;
    b_bus.i_dmem_ready = 1'b0; b_bus.i_mdu_done = 1'b0;

    // ---- reset held: every output low even with imem ready ----
    cyc();
    cyc();
    settle();
    check("rst_imem_req", a_bus.o_imem_req, 0);
    check("rst_ir_wr",    a_bus.o_ir_wr_en, 0);
    check("rst_state",    a_bus.o_state, 0);
    check("rst_retired",  a_bus.o_retired, 0);
    a_bus.i_imem_ready = 1'b0;
    cyc();
    rst = 1'b1;
    settle();
    check("rel_imem_req", a_bus.o_imem_req, 1);

    // ---- ALU class on dut_a ----
    run_alu_a("addi",     32'h00500093, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_alu_a("addi_b30", 32'h40000093, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_alu_a("sub",      32'h40208233, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    run_alu_a("srai",     32'h4030D293, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1);
    run_alu_a("sltiu",    32'h0070B313, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1);
    run_alu_a("nop",      32'h00000013, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // ---- lw x2,0(x1): three MEM cycles, ready on the third ----
    fetch_a(32'h0000A103);
    cyc();
    settle();
    check("lw_in_sel", a_bus.o_alu_input_sel, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 2) a_bus.i_dmem_ready = 1'b1;
      settle();
      check("lw_mem_state", a_bus.o_state, 3);
      check("lw_dmem_req",  a_bus.o_dmem_req, 1);
      check("lw_dmem_wr",   a_bus.o_dmem_wr_en, 0);
      check("lw_pc_wr",     a_bus.o_pc_wr_en, 0);
    end
    cyc();
    a_bus.i_dmem_ready = 1'b0;
    settle();
    check("lw_wb_state",  a_bus.o_state, 4);
    check("lw_wb_sel",    a_bus.o_reg_wr_sel, 1);
    check("lw_reg_wr",    a_bus.o_reg_wr_en, 1);
    cyc();
    a_ret++;
    settle();
    check("lw_ret", a_bus.o_retired, a_ret);

    // ---- sw x2,4(x1): store retires from MEM ----
    fetch_a(32'h0020A223);
    cyc();
    cyc();
    a_bus.i_dmem_ready = 1'b1;
    settle();
    check("sw_mem_state", a_bus.o_state, 3);
    check("sw_dmem_wr",   a_bus.o_dmem_wr_en, 1);
    check("sw_pc_wr",     a_bus.o_pc_wr_en, 1);
    cyc();
    a_bus.i_dmem_ready = 1'b0;
    a_ret++;
    settle();
    check("sw_fetch", a_bus.o_state, 0);
    check("sw_ret",   a_bus.o_retired, a_ret);

    // ---- bltu x1,x2,8: branch retires from EXEC ----
    fetch_a(32'h0020E463);
    cyc();
    settle();
    check("bltu_exec",  a_bus.o_state, 2);
    check("bltu_pc_wr", a_bus.o_pc_wr_en, 1);
    check("bltu_sign",  a_bus.o_alu_sign_sel, 1);
    cyc();
    a_ret++;
    settle();
    check("bltu_fetch", a_bus.o_state, 0);
    check("bltu_ret",   a_bus.o_retired, a_ret);

    // ---- mul x3,x1,x2 with MDU enabled ----
    fetch_a(32'h022081B3);
    settle();
    check("mul_dec_start", a_bus.o_mdu_start, 0);
    cyc();
    settle();
    check("mul_mdu_state", a_bus.o_state, 5);
    check("mul_start1",    a_bus.o_mdu_start, 1);
    cyc();
    settle();
    check("mul_start2",    a_bus.o_mdu_start, 0);
    cyc();
    a_bus.i_mdu_done = 1'b1;
    settle();
    check("mul_wait",      a_bus.o_state, 5);
    cyc();
    a_bus.i_mdu_done = 1'b0;
    settle();
    check("mul_wb",        a_bus.o_state, 4);
    check("mul_reg_wr",    a_bus.o_reg_wr_en, 1);
    cyc();
    a_ret++;
    settle();
    check("mul_ret", a_bus.o_retired, a_ret);

    // ---- jal x1,0 ----
    fetch_a(32'h000000EF);
    cyc();
    settle();
    check("jal_jump",   a_bus.o_jump_sel, 1);
    check("jal_jtype",  a_bus.o_jump_type_sel, 0);
    cyc();
    settle();
    check("jal_wb_sel", a_bus.o_reg_wr_sel, 4);
    check("jal_reg_wr", a_bus.o_reg_wr_en, 1);
    cyc();
    a_ret++;
    settle();
    check("jal_ret", a_bus.o_retired, a_ret);

    // ---- ecall: sticky halt, requests stay low ----
    fetch_a(32'h00000073);
    cyc();
    a_bus.i_imem_ready = 1'b1;
    settle();
    check("halt_state", a_bus.o_state, 6);
    check("halt_flag",  a_bus.o_halt, 1);
    cyc();
    settle();
    check("halt_sticky",   a_bus.o_halt, 1);
    check("halt_imem_req", a_bus.o_imem_req, 0);
    check("halt_ir_wr",    a_bus.o_ir_wr_en, 0);
    check("halt_ret",      a_bus.o_retired, a_ret);
    a_bus.i_imem_ready = 1'b0;

    // ---- reset mid-WB aborts the instruction ----
    do_reset();
    settle();
    check("post_halt_flag", a_bus.o_halt, 0);
    fetch_a(32'h00500093);
    cyc();
    cyc();
    settle();
    check("midwb_state_pre", a_bus.o_state, 4);
    rst = 1'b0;
    #1;
    check("midwb_reg_wr",  a_bus.o_reg_wr_en, 0);
    check("midwb_pc_wr",   a_bus.o_pc_wr_en, 0);
    check("midwb_state",   a_bus.o_state, 0);
    check("midwb_in_sel",  a_bus.o_alu_input_sel, 0);
    check("midwb_imem",    a_bus.o_imem_req, 0);
    check("midwb_retired", a_bus.o_retired, 0);
    cyc();
    rst = 1'b1;
    settle();
    check("midwb_rel_req", a_bus.o_imem_req, 1);

    // ---- dut_b: fetch timeout with imem never ready ----
    do_reset();
    for (int i = 0; i < 4; i++) begin
      settle();
      check("to_fetch_wait", b_bus.o_state, 0);
      cyc();
    end
    settle();
    check("to_trap_state", b_bus.o_state, 7);
    check("to_trap_flag",  b_bus.o_trap, 1);
    check("to_imem_req",   b_bus.o_imem_req, 0);

    // ---- dut_b: ready on the 4th wait cycle beats the timeout ----
    do_reset();
    for (int i = 0; i < 3; i++) begin
      settle();
      check("rdy4_wait", b_bus.o_state, 0);
      cyc();
    end
    fetch_b(32'h00500093);
    settle();
    check("rdy4_decode", b_bus.o_state, 1);
    cyc();
    cyc();
    cyc();
    b_ret++;
    settle();
    check("rdy4_ret", b_bus.o_retired, b_ret);

    // ---- dut_b: mul with MDU disabled traps, nothing retires ----
    fetch_b(32'h022081B3);
    cyc();
    settle();
    check("mul_off_trap",  b_bus.o_trap, 1);
    check("mul_off_state", b_bus.o_state, 7);
    cyc();
    settle();
    check("mul_off_start", b_bus.o_mdu_start, 0);
    check("mul_off_ret",   b_bus.o_retired, b_ret);

    // ---- dut_b: all-zero opcode is illegal ----
    do_reset();
    fetch_b(32'h00000000);
    cyc();
    settle();
    check("ill_trap", b_bus.o_state, 7);

    // ---- dut_b: data memory never ready -> trap after 4 MEM cycles ----
    do_reset();
    fetch_b(32'h0000A103);
    cyc();
    for (int i = 0; i < 4; i++) begin
      cyc();
      settle();
      check("memto_wait", b_bus.o_state, 3);
    end
    cyc();
    settle();
    check("memto_trap", b_bus.o_state, 7);
    check("memto_ret",  b_bus.o_retired, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
